// File: rtl/sa_result_collector.sv
// Realigns the column-skewed outputs of a weight-stationary systolic array into
// whole rows and queues them behind a valid/ready port with credit-based flow control.
package sa_result_collector_pkg;
    typedef enum logic [1:0] {
        CMD_IDLE          = 2'd0,
        CMD_WRITE_WEIGHTS = 2'd1,
        CMD_STREAM        = 2'd2
    } command_t;
endpackage

module sa_result_collector
    import sa_result_collector_pkg::*;
#(
    parameter int SA_SIZE         = 8,
    parameter int ACTIVATION_SIZE = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  command_t                            cmd,
    input  logic                                vec_valid,
    input  logic [SA_SIZE*ACTIVATION_SIZE-1:0]  sa_outputs,
    output logic                                stream_allowed,
    output logic [SA_SIZE*ACTIVATION_SIZE-1:0]  row_data,
    output logic                                row_valid,
    input  logic                                row_ready,
    output logic                                busy,
    output logic                                protocol_err
);
    localparam int W     = ACTIVATION_SIZE;
    localparam int N     = SA_SIZE;
    localparam int LAST  = 2*N - 2;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             step;
    logic             tag_in;
    logic             push;
    logic             pop;
    logic [LAST:1]    tags;
    logic [15:0]      inflight;
    logic [N*W-1:0]   aligned;
    logic [N*W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= LAST; i++) begin
            inflight = inflight + 16'(tags[i]);
        end
    end

    assign step           = (cmd == CMD_STREAM);
    assign stream_allowed = (inflight + 16'(count)) < 16'(FIFO_DEPTH);
    assign tag_in         = step && vec_valid && stream_allowed;
    assign push           = step && tags[LAST];
    assign row_valid      = (count != '0);
    assign pop            = row_valid && row_ready;
    assign row_data       = row_valid ? mem[rd_ptr] : '0;
    assign busy           = (inflight != '0) || row_valid;

    // Stage 0 of the tag pipeline is the combinational tag_in; stages 1..2N-2 are registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tags         <= '0;
            protocol_err <= 1'b0;
        end else if (step) begin
            tags <= {tags[LAST-1:1], tag_in};
            if (vec_valid && !stream_allowed) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign aligned[(N-1)*W +: W] = sa_outputs[(N-1)*W +: W];

    for (genvar c = 0; c < N - 1; c++) begin : g_deskew
        localparam int DEPTH = N - 1 - c;
        logic [W-1:0] line [DEPTH];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                for (int k = 0; k < DEPTH; k++) begin
                    line[k] <= '0;
                end
            end else if (step) begin
                line[0] <= sa_outputs[c*W +: W];
                for (int k = 1; k < DEPTH; k++) begin
                    line[k] <= line[k-1];
                end
            end
        end

        assign aligned[c*W +: W] = line[DEPTH-1];
    end

    // Credit accounting guarantees a push never meets a full FIFO, so no overflow guard.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr] <= aligned;
        end
    end

endmodule

// File: tb/tb_sa_result_collector.sv
// Bench for sa_result_collector: directed scenarios followed by a random run, every
// cycle compared against a queue model built from step history and tag step numbers.
module tb_sa_result_collector;
    import sa_result_collector_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int D   = 2;
    localparam int LAT = 2*N - 2;

    localparam logic [N*W-1:0] ROW_A = {32'h603, 32'h502, 32'h401, 32'h300};
    localparam logic [N*W-1:0] ROW_B = {32'h703, 32'h602, 32'h501, 32'h400};

    logic           clk = 1'b0;
    logic           resetn;
    command_t       cmd;
    logic           vec_valid;
    logic           row_ready;
    logic [N*W-1:0] sa_outputs;
    logic [N*W-1:0] row_data;
    logic           stream_allowed;
    logic           row_valid;
    logic           busy;
    logic           protocol_err;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    int pat      = 0;
    int tc       = 0;

    // Reference model: per-step input history, tag step numbers in flight, expected FIFO rows.
    logic [N*W-1:0] hist [64];
    int             pend [$];
    logic [N*W-1:0] exp_q [$];
    logic           exp_err  = 1'b0;
    int             step_cnt = 0;

    logic [N*W-1:0] got [$];
    int             got_cyc [$];

    always #5 clk = ~clk;

    sa_result_collector #(
        .SA_SIZE(N),
        .ACTIVATION_SIZE(W),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cmd(cmd),
        .vec_valid(vec_valid),
        .sa_outputs(sa_outputs),
        .stream_allowed(stream_allowed),
        .row_data(row_data),
        .row_valid(row_valid),
        .row_ready(row_ready),
        .busy(busy),
        .protocol_err(protocol_err)
    );

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] got_row(input int i);
        return (got.size() > i) ? got[i] : 'x;
    endfunction

    function automatic int got_at(input int i);
        return (got_cyc.size() > i) ? got_cyc[i] : -1;
    endfunction

    task automatic check_output();
        int occ;
        occ = pend.size() + exp_q.size();
        check_bit("stream_allowed", stream_allowed, occ < D);
        check_bit("row_valid", row_valid, exp_q.size() != 0);
        check_row("row_data", row_data, (exp_q.size() != 0) ? exp_q[0] : '0);
        check_bit("busy", busy, occ != 0);
        check_bit("protocol_err", protocol_err, exp_err);
    endtask

    task automatic model_edge();
        int             occ;
        logic           pop_now;
        logic           have_row;
        logic [N*W-1:0] row;
        if (!resetn) begin
            pend.delete();
            exp_q.delete();
            exp_err = 1'b0;
            return;
        end
        occ      = pend.size() + exp_q.size();
        pop_now  = row_ready && (exp_q.size() != 0);
        have_row = 1'b0;
        row      = '0;
        if (cmd == CMD_STREAM) begin
            hist[step_cnt % 64] = sa_outputs;
            if (vec_valid) begin
                if (occ < D) pend.push_back(step_cnt);
                else exp_err = 1'b1;
            end
            if (pend.size() != 0 && pend[0] == step_cnt - LAT) begin
                for (int c = 0; c < N; c++) begin
                    row[c*W +: W] = hist[(pend[0] + N - 1 + c) % 64][c*W +: W];
                end
                void'(pend.pop_front());
                have_row = 1'b1;
            end
            step_cnt++;
        end
        if (pop_now) void'(exp_q.pop_front());
        if (have_row) exp_q.push_back(row);
    endtask

    task automatic apply_stimulus(input command_t c, input logic vv, input logic [N*W-1:0] d,
                                  input logic rdy, input logic rn);
        cmd        = c;
        vec_valid  = vv;
        sa_outputs = d;
        row_ready  = rdy;
        resetn     = rn;
        check_output();
        if (row_valid && row_ready && resetn) begin
            got.push_back(row_data);
            got_cyc.push_back(cyc_cnt);
        end
        @(posedge clk);
        model_edge();
        #1;
        cyc_cnt++;
    endtask

    task automatic stream(input logic vv, input logic rdy);
        logic [N*W-1:0] d;
        for (int c = 0; c < N; c++) begin
            d[c*W +: W] = (pat << 8) | c;
        end
        pat++;
        apply_stimulus(CMD_STREAM, vv, d, rdy, 1'b1);
    endtask

    task automatic do_reset();
        apply_stimulus(CMD_IDLE, 1'b0, '0, 1'b0, 1'b0);
        got.delete();
        got_cyc.delete();
        pat = 0;
    endtask

    initial begin
        cmd        = CMD_IDLE;
        vec_valid  = 1'b0;
        sa_outputs = '0;
        row_ready  = 1'b0;
        resetn     = 1'b0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset values
        do_reset();
        check_bit("rst_stream_allowed", stream_allowed, 1'b1);
        check_bit("rst_row_valid", row_valid, 1'b0);
        check_row("rst_row_data", row_data, '0);
        check_bit("rst_busy", busy, 1'b0);

        // Single row latency
        tc = cyc_cnt;
        stream(1'b1, 1'b1);
        repeat (9) stream(1'b0, 1'b1);
        check_int("single_count", got.size(), 1);
        check_row("single_row", got_row(0), ROW_A);
        check_int("single_latency", got_at(0) - tc, 7);

        // Back-to-back tags
        do_reset();
        stream(1'b1, 1'b1);
        stream(1'b1, 1'b1);
        check_bit("b2b_credit_closed", stream_allowed, 1'b0);
        repeat (10) stream(1'b0, 1'b1);
        check_int("b2b_count", got.size(), 2);
        check_row("b2b_row0", got_row(0), ROW_A);
        check_row("b2b_row1", got_row(1), ROW_B);
        check_int("b2b_spacing", got_at(1) - got_at(0), 1);

        // Freeze between steps 2 and 3
        do_reset();
        tc = cyc_cnt;
        stream(1'b1, 1'b1);
        stream(1'b0, 1'b1);
        stream(1'b0, 1'b1);
        repeat (5) apply_stimulus(CMD_WRITE_WEIGHTS, 1'b1,
                                  {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1);
        repeat (8) stream(1'b0, 1'b1);
        check_int("freeze_count", got.size(), 1);
        check_row("freeze_row", got_row(0), ROW_A);
        check_int("freeze_latency", got_at(0) - tc, 12);

        // Backpressure and credit
        do_reset();
        stream(1'b1, 1'b0);
        stream(1'b1, 1'b0);
        repeat (8) stream(1'b0, 1'b0);
        check_bit("bp_full_valid", row_valid, 1'b1);
        check_bit("bp_credit", stream_allowed, 1'b0);
        check_row("bp_head", row_data, ROW_A);
        repeat (2) apply_stimulus(CMD_IDLE, 1'b0, '0, 1'b0, 1'b1);
        check_row("bp_head_stable", row_data, ROW_A);

        // Violation while credit is exhausted
        stream(1'b1, 1'b0);
        check_bit("viol_err", protocol_err, 1'b1);
        repeat (8) stream(1'b0, 1'b0);
        check_bit("viol_err_sticky", protocol_err, 1'b1);
        check_row("viol_head_intact", row_data, ROW_A);
        apply_stimulus(CMD_IDLE, 1'b0, '0, 1'b1, 1'b1);
        check_bit("credit_reopened", stream_allowed, 1'b1);
        repeat (4) apply_stimulus(CMD_IDLE, 1'b0, '0, 1'b1, 1'b1);
        check_int("viol_count", got.size(), 2);
        check_row("viol_row0", got_row(0), ROW_A);
        check_row("viol_row1", got_row(1), ROW_B);
        check_bit("viol_err_final", protocol_err, 1'b1);

        // Reset mid-flight at step 3
        do_reset();
        stream(1'b1, 1'b1);
        stream(1'b0, 1'b1);
        stream(1'b0, 1'b1);
        apply_stimulus(CMD_STREAM, 1'b0, '1, 1'b1, 1'b0);
        check_bit("midrst_valid", row_valid, 1'b0);
        check_row("midrst_data", row_data, '0);
        check_bit("midrst_credit", stream_allowed, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_err", protocol_err, 1'b0);
        repeat (10) stream(1'b0, 1'b1);
        check_int("midrst_no_row", got.size(), 0);

        // Random traffic against the model
        do_reset();
        repeat (400) begin
            int       r;
            command_t c;
            r = int'($urandom_range(99, 0));
            c = (r < 70) ? CMD_STREAM : ((r < 85) ? CMD_IDLE : CMD_WRITE_WEIGHTS);
            apply_stimulus(c, ($urandom_range(2, 0) == 0),
                           {$urandom(), $urandom(), $urandom(), $urandom()},
                           ($urandom_range(3, 0) != 0), ($urandom_range(99, 0) >= 2));
        end
        repeat (20) apply_stimulus(CMD_STREAM, 1'b0, '0, 1'b1, 1'b1);
        check_bit("final_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
